trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Trap/return sequencer between the pipeline and the CSR block. Each cycle it samples the retiring instruction's exception flags, xRET request and pending machine interrupts, and selects one event by fixed priority. It then runs a stall → CSR commit → PC redirect sequence, so the CSR block receives exactly one trap (or return) pulse per event with cause, tval and epc already resolved.

Parameters:
XLEN, 32, datapath width.
CAUSE_W, 5, width of the exception-code field placed in o_cause[CAUSE_W-1:0].

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous reset, active-high.
i_inst_valid  in  1  instruction at the retire point is valid this cycle.
i_pc  in  XLEN  PC of the retiring instruction.
i_inst  in  32  encoding of the retiring instruction.
i_badaddr  in  XLEN  faulting address for misaligned faults.
i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall, i_ex_ld_addr, i_ex_st_addr  in  1 each  exception flags.
i_mret  in  1  retiring instruction is MRET.
i_mstatus_mie  in  1  global machine interrupt enable.
i_mie  in  3  per-source enables {meie, mtie, msie}.
i_mip  in  3  pending sources {meip, mtip, msip}.
i_mem_busy  in  1  data-memory transaction outstanding.
i_tvec  in  XLEN  trap vector from the CSR block.
i_epc  in  XLEN  saved epc from the CSR block.
o_stall  out  1  freeze fetch/retire.
o_flush  out  1  kill younger pipeline stages.
o_trap_valid  out  1  one-cycle pulse: CSR block commits a trap.
o_eret  out  1  one-cycle pulse: CSR block pops the mstatus stack.
o_cause  out  XLEN  bit XLEN-1 = interrupt flag, low bits = code.
o_tval  out  XLEN  trap value.
o_epc  out  XLEN  PC to save.
o_redirect_valid  out  1  one-cycle pulse: load o_redirect_pc into the PC.
o_redirect_pc  out  XLEN  new PC.

Behaviour:
- States: IDLE, DRAIN, COMMIT, REDIRECT, ERET.
- Reset (any state, including mid-sequence): state goes to IDLE. o_stall, o_flush, o_trap_valid, o_eret and o_redirect_valid go to 0. o_cause, o_tval, o_epc and o_redirect_pc go to 0.
- The block acts only when state is IDLE and i_inst_valid=1.
- Exception priority, highest first, with cause code / tval:
  - inst_addr: 0 / i_badaddr.
  - illegal: 2 / i_inst zero-extended.
  - ebreak: 3 / i_pc.
  - ecall: 11 / 0.
  - ld_addr: 4 / i_badaddr.
  - st_addr: 6 / i_badaddr.
- Any exception beats MRET and interrupts in the same cycle.
- Interrupt pending = i_mstatus_mie & |(i_mie & i_mip). Interrupt priority: MEI (11) > MSI (3) > MTI (7). cause = {1, code}, tval = 0.
- Exception at cycle N:
  - o_stall=1 combinationally in N.
  - cause, tval and epc=i_pc are latched in N; state goes to COMMIT.
  - N+1 (COMMIT): o_trap_valid=1, o_flush=1, o_stall=1.
  - N+2 (REDIRECT): o_redirect_valid=1, o_redirect_pc={i_tvec[XLEN-1:2], 2'b00}, o_stall=1.
  - N+3: IDLE, o_stall=0.
- Interrupt at cycle N (no exception, no MRET):
  - The instruction is not executed; epc=i_pc.
  - o_stall=1 in N.
  - If i_mem_busy=1, go to DRAIN; otherwise go to COMMIT, then same timing as an exception.
- DRAIN:
  - o_stall=1.
  - Leave when i_mem_busy=0, then go to COMMIT.
  - If the interrupt is no longer pending on that cycle, abort to IDLE: no trap pulse, o_stall=0 next cycle.
  - Cause is re-evaluated on the exit cycle, so a higher-priority source appearing during DRAIN wins.
- MRET at cycle N (no exception):
  - o_stall=1 in N.
  - N+1 (ERET): o_eret=1, o_flush=1, o_stall=1.
  - N+2 (REDIRECT): o_redirect_pc={i_epc[XLEN-1:2], 2'b00}.
  - MRET takes precedence over a pending interrupt in cycle N; the interrupt is evaluated again after return.
- i_inst_valid=0 in IDLE: no action, even if an interrupt is pending.
- Inputs in states other than IDLE are ignored, except i_mem_busy and pending in DRAIN, and i_tvec/i_epc in REDIRECT.
- o_cause, o_tval and o_epc hold their values until the next latch.
- All pulses are exactly one cycle. At most one of o_trap_valid and o_eret is high in any cycle.

Test Plan:
- Illegal instruction: i_inst=32'hFFFFFFFF, i_pc=0x100, i_tvec=0x200 → o_trap_valid at N+1 with o_cause=2, o_tval=0xFFFFFFFF, o_epc=0x100; o_redirect_pc=0x200 at N+2; o_stall low from N+3.
- Simultaneous ld_addr and ecall plus pending MTI, i_pc=0x40 → o_cause=11, o_tval=0; only one o_trap_valid pulse.
- MTI with i_mstatus_mie=1, i_mie=3'b010, i_mip=3'b010, i_mem_busy high for 3 cycles → o_stall held, trap commits one cycle after i_mem_busy falls, o_cause=0x80000007.
- Interrupt withdrawn during DRAIN (i_mip→0 before i_mem_busy falls) → return to IDLE, no o_trap_valid, no o_redirect_valid.
- MRET with i_epc=0x1235 → o_eret at N+1, o_redirect_pc=0x1234 at N+2; with MEI pending in N, the MEI trap is taken after return with o_cause=0x8000000B.
- i_rst asserted in COMMIT → next cycle all outputs 0 and state IDLE; a fresh ecall afterwards gives normal timing with o_cause=11.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap/return sequencer: picks one event per retiring instruction by fixed priority
// and walks stall -> CSR commit -> PC redirect so the CSR block sees a single pulse.
module trap_ctrl #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_badaddr,
  input  logic            i_ex_inst_addr,
  input  logic            i_ex_illegal,
  input  logic            i_ex_ebreak,
  input  logic            i_ex_ecall,
  input  logic            i_ex_ld_addr,
  input  logic            i_ex_st_addr,
  input  logic            i_mret,
  input  logic            i_mstatus_mie,
  input  logic [2:0]      i_mie,
  input  logic [2:0]      i_mip,
  input  logic            i_mem_busy,
  input  logic [XLEN-1:0] i_tvec,
  input  logic [XLEN-1:0] i_epc,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_trap_valid,
  output logic            o_eret,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_tval,
  output logic [XLEN-1:0] o_epc,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  typedef enum logic [2:0] {IDLE, DRAIN, COMMIT, REDIRECT, ERET} state_e;

  state_e          state_q;
  logic            ret_q;
  logic [XLEN-1:0] cause_q, tval_q, epc_q, rpc_q;

  logic            take, exc, irq_pend;
  logic [2:0]      irq_act;
  logic [XLEN-1:0] exc_cause_d, exc_tval_d, irq_cause_d, redirect_tgt;
  logic [CAUSE_W-1:0] irq_code;

  assign take     = (state_q == IDLE) && i_inst_valid;
  assign exc      = i_ex_inst_addr | i_ex_illegal | i_ex_ebreak | i_ex_ecall |
                    i_ex_ld_addr | i_ex_st_addr;
  assign irq_act  = i_mie & i_mip;
  assign irq_pend = i_mstatus_mie & (|irq_act);

  always_comb begin
    exc_cause_d = '0;
    exc_tval_d  = '0;
    if (i_ex_inst_addr) begin
      exc_cause_d[CAUSE_W-1:0] = CAUSE_W'(0);
      exc_tval_d               = i_badaddr;
    end else if (i_ex_illegal) begin
      exc_cause_d[CAUSE_W-1:0] = CAUSE_W'(2);
      exc_tval_d               = XLEN'(i_inst);
    end else if (i_ex_ebreak) begin
      exc_cause_d[CAUSE_W-1:0] = CAUSE_W'(3);
      exc_tval_d               = i_pc;
    end else if (i_ex_ecall) begin
      exc_cause_d[CAUSE_W-1:0] = CAUSE_W'(11);
    end else if (i_ex_ld_addr) begin
      exc_cause_d[CAUSE_W-1:0] = CAUSE_W'(4);
      exc_tval_d               = i_badaddr;
    end else if (i_ex_st_addr) begin
      exc_cause_d[CAUSE_W-1:0] = CAUSE_W'(6);
      exc_tval_d               = i_badaddr;
    end
  end

  // Interrupt order is MEI > MSI > MTI, not bit order.
  always_comb begin
    if (irq_act[2])      irq_code = CAUSE_W'(11);
    else if (irq_act[0]) irq_code = CAUSE_W'(3);
    else                 irq_code = CAUSE_W'(7);
    irq_cause_d                = '0;
    irq_cause_d[XLEN-1]        = 1'b1;
    irq_cause_d[CAUSE_W-1:0]   = irq_code;
  end

  assign redirect_tgt = ret_q ? {i_epc[XLEN-1:2], 2'b00} : {i_tvec[XLEN-1:2], 2'b00};

  assign o_stall          = (state_q != IDLE) || (take && (exc || i_mret || irq_pend));
  assign o_trap_valid     = (state_q == COMMIT);
  assign o_eret           = (state_q == ERET);
  assign o_flush          = (state_q == COMMIT) || (state_q == ERET);
  assign o_redirect_valid = (state_q == REDIRECT);
  // tvec/epc are sampled live in REDIRECT; the register just holds the last target.
  assign o_redirect_pc    = (state_q == REDIRECT) ? redirect_tgt : rpc_q;
  assign o_cause          = cause_q;
  assign o_tval           = tval_q;
  assign o_epc            = epc_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ret_q   <= 1'b0;
      cause_q <= '0;
      tval_q  <= '0;
      epc_q   <= '0;
      rpc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          if (exc) begin
            cause_q <= exc_cause_d;
            tval_q  <= exc_tval_d;
            epc_q   <= i_pc;
            ret_q   <= 1'b0;
            state_q <= COMMIT;
          end else if (i_mret) begin
            ret_q   <= 1'b1;
            state_q <= ERET;
          end else if (irq_pend) begin
            cause_q <= irq_cause_d;
            tval_q  <= '0;
            epc_q   <= i_pc;
            ret_q   <= 1'b0;
            state_q <= i_mem_busy ? DRAIN : COMMIT;
          end
        end
        DRAIN: if (!i_mem_busy) begin
          if (irq_pend) begin
            cause_q <= irq_cause_d;
            tval_q  <= '0;
            state_q <= COMMIT;
          end else begin
            state_q <= IDLE;
          end
        end
        COMMIT:   state_q <= REDIRECT;
        ERET:     state_q <= REDIRECT;
        REDIRECT: begin
          rpc_q   <= redirect_tgt;
          state_q <= IDLE;
        end
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed vector table, corner sequences,
// and random single-instruction transactions against a priority-list model.
module tb_trap_ctrl;
  logic        clk = 0, rst;
  logic        inst_valid, ex_ia, ex_il, ex_eb, ex_ec, ex_ld, ex_st, mret, mst, mem_busy;
  logic [31:0] pc, inst, bad, tvec, epc;
  logic [2:0]  mie, mip;
  logic        stall, flush, trap_valid, eret, redirect_valid;
  logic [31:0] cause, tval, epc_o, redirect_pc;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .CAUSE_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_inst_valid(inst_valid), .i_pc(pc), .i_inst(inst),
    .i_badaddr(bad), .i_ex_inst_addr(ex_ia), .i_ex_illegal(ex_il), .i_ex_ebreak(ex_eb),
    .i_ex_ecall(ex_ec), .i_ex_ld_addr(ex_ld), .i_ex_st_addr(ex_st), .i_mret(mret),
    .i_mstatus_mie(mst), .i_mie(mie), .i_mip(mip), .i_mem_busy(mem_busy),
    .i_tvec(tvec), .i_epc(epc), .o_stall(stall), .o_flush(flush),
    .o_trap_valid(trap_valid), .o_eret(eret), .o_cause(cause), .o_tval(tval),
    .o_epc(epc_o), .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc));

  typedef struct {
    logic v; logic [5:0] ex; logic mret, mst; logic [2:0] mie, mip;
    logic [31:0] pc, inst, bad, tvec, epc;
    int kind; logic [31:0] cause, tval;   // kind: 0 none, 1 trap, 2 eret
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic step(); @(posedge clk); #1; endtask

  task automatic clear_ev();
    inst_valid = 0; {ex_ia, ex_il, ex_eb, ex_ec, ex_ld, ex_st} = '0; mret = 0;
  endtask

  // Reference: walk the priority lists of the architectural rules.
  function automatic void ref_evt(input logic v, input logic [5:0] ex, input logic r,
      input logic ms, input logic [2:0] ie, input logic [2:0] ip,
      input logic [31:0] p, input logic [31:0] in, input logic [31:0] b,
      output int kind, output logic [31:0] c, output logic [31:0] t);
    int codes[6] = '{0, 2, 3, 11, 4, 6};
    int ibit[3]  = '{2, 0, 1};
    int icode[3] = '{11, 3, 7};
    kind = 0; c = 0; t = 0;
    if (!v) return;
    for (int i = 0; i < 6; i++)
      if (ex[5-i]) begin
        kind = 1; c = codes[i];
        case (codes[i])
          2: t = in;
          3: t = p;
          11: t = 0;
          default: t = b;
        endcase
        return;
      end
    if (r) begin kind = 2; return; end
    if (ms)
      for (int i = 0; i < 3; i++)
        if (ie[ibit[i]] && ip[ibit[i]]) begin
          kind = 1; c = 32'h8000_0000 + icode[i]; t = 0; return;
        end
  endfunction

  // Inputs for cycle N already driven (at posedge+1); checks N..N+3.
  task automatic do_txn(input string nm, input int kind, input logic [31:0] c,
      input logic [31:0] t, input logic [31:0] p, input logic [31:0] tgt);
    #1 chk({nm, ".stallN"}, {31'b0, stall}, {31'b0, kind != 0});
    step(); clear_ev();
    chk({nm, ".trapN1"}, {31'b0, trap_valid}, {31'b0, kind == 1});
    chk({nm, ".eretN1"}, {31'b0, eret}, {31'b0, kind == 2});
    chk({nm, ".flushN1"}, {31'b0, flush}, {31'b0, kind != 0});
    if (kind == 1) begin
      chk({nm, ".cause"}, cause, c);
      chk({nm, ".tval"}, tval, t);
      chk({nm, ".epc"}, epc_o, p);
    end
    step();
    chk({nm, ".rvalidN2"}, {31'b0, redirect_valid}, {31'b0, kind != 0});
    if (kind != 0) chk({nm, ".rpcN2"}, redirect_pc, tgt & 32'hFFFF_FFFC);
    chk({nm, ".trapN2"}, {31'b0, trap_valid | eret}, 32'd0);
    step();
    chk({nm, ".stallN3"}, {31'b0, stall}, 32'd0);
    chk({nm, ".rvalidN3"}, {31'b0, redirect_valid}, 32'd0);
  endtask

  task automatic apply(input vec_t x);
    inst_valid = x.v; {ex_ia, ex_il, ex_eb, ex_ec, ex_ld, ex_st} = x.ex; mret = x.mret;
    mst = x.mst; mie = x.mie; mip = x.mip; pc = x.pc; inst = x.inst; bad = x.bad;
    tvec = x.tvec; epc = x.epc;
  endtask

  vec_t tbl[10];

  initial begin
    vec_t x;
    int k; logic [31:0] c, t;
    tbl[0] = '{1, 6'b010000, 0, 0, 3'b000, 3'b000, 32'h100, 32'hFFFF_FFFF, 0, 32'h200, 0, 1, 2, 32'hFFFF_FFFF};
    tbl[1] = '{1, 6'b000110, 0, 1, 3'b010, 3'b010, 32'h40, 0, 32'h99, 32'h200, 0, 1, 11, 0};
    tbl[2] = '{1, 6'b111111, 1, 1, 3'b111, 3'b111, 32'h80, 32'h13, 32'hDEAD_0001, 32'h203, 0, 1, 0, 32'hDEAD_0001};
    tbl[3] = '{1, 6'b001001, 0, 0, 0, 0, 32'h300, 0, 32'h55, 32'h400, 0, 1, 3, 32'h300};
    tbl[4] = '{1, 6'b000001, 0, 0, 0, 0, 32'h304, 0, 32'h77, 32'h400, 0, 1, 6, 32'h77};
    tbl[5] = '{1, 6'b000011, 0, 0, 0, 0, 32'h308, 0, 32'h79, 32'h400, 0, 1, 4, 32'h79};
    tbl[6] = '{1, 6'b000000, 0, 0, 3'b111, 3'b111, 32'h30C, 0, 0, 32'h400, 0, 0, 0, 0};
    tbl[7] = '{0, 6'b000000, 0, 1, 3'b111, 3'b111, 32'h310, 0, 0, 32'h400, 0, 0, 0, 0};
    tbl[8] = '{1, 6'b000000, 0, 1, 3'b011, 3'b011, 32'h314, 0, 0, 32'h500, 0, 1, 32'h8000_0003, 0};
    tbl[9] = '{1, 6'b001000, 1, 0, 0, 0, 32'h318, 0, 0, 32'h600, 32'h999, 1, 3, 32'h318};

    rst = 1; clear_ev(); mst = 0; mie = 0; mip = 0; mem_busy = 0;
    pc = 0; inst = 0; bad = 0; tvec = 0; epc = 0;
    step(); step();
    chk("rst.stall", {31'b0, stall}, 0);
    chk("rst.pulses", {27'b0, flush, trap_valid, eret, redirect_valid, 1'b0}, 0);
    chk("rst.cause", cause, 0); chk("rst.tval", tval, 0);
    chk("rst.epc", epc_o, 0);   chk("rst.rpc", redirect_pc, 0);
    rst = 0;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      do_txn($sformatf("vec%0d", i), tbl[i].kind, tbl[i].cause, tbl[i].tval, tbl[i].pc,
             tbl[i].kind == 2 ? tbl[i].epc : tbl[i].tvec);
    end

    // MTI with memory busy for three cycles
    mst = 1; mie = 3'b010; mip = 3'b010; pc = 32'h700; tvec = 32'h800; mem_busy = 1;
    inst_valid = 1;
    #1 chk("drain.stallN", {31'b0, stall}, 1);
    step(); clear_ev();
    for (int i = 0; i < 2; i++) begin
      chk("drain.stall", {31'b0, stall}, 1);
      chk("drain.notrap", {31'b0, trap_valid}, 0);
      if (i == 1) mem_busy = 0;
      step();
    end
    chk("drain.trap", {31'b0, trap_valid}, 1);
    chk("drain.cause", cause, 32'h8000_0007);
    chk("drain.epc", epc_o, 32'h700);
    step();
    chk("drain.rpc", redirect_pc, 32'h800);
    step();
    chk("drain.stall_end", {31'b0, stall}, 0);
    mip = 0;

    // Interrupt withdrawn while draining
    mip = 3'b010; mem_busy = 1; inst_valid = 1;
    step(); clear_ev(); mip = 0;
    step(); mem_busy = 0;
    #1 chk("wd.stall_drain", {31'b0, stall}, 1);
    step();
    chk("wd.stall", {31'b0, stall}, 0);
    chk("wd.notrap", {31'b0, trap_valid}, 0);
    step();
    chk("wd.noredir", {31'b0, redirect_valid | trap_valid}, 0);

    // MRET with MEI pending: return first, then take MEI
    mie = 3'b100; mip = 3'b100; epc = 32'h1235; mret = 1; inst_valid = 1; pc = 32'h900;
    do_txn("mret", 2, 0, 0, 32'h900, 32'h1235);
    inst_valid = 1; pc = 32'h1234; tvec = 32'hA00;
    do_txn("mei", 1, 32'h8000_000B, 0, 32'h1234, 32'hA00);
    mip = 0; mie = 0;

    // Reset in COMMIT
    ex_ec = 1; inst_valid = 1; pc = 32'hB00;
    step(); clear_ev();
    chk("rc.commit", {31'b0, trap_valid}, 1);
    rst = 1;
    step(); rst = 0;
    chk("rc.pulses", {27'b0, stall, flush, trap_valid, eret, redirect_valid}, 0);
    chk("rc.cause", cause, 0); chk("rc.epc", epc_o, 0); chk("rc.rpc", redirect_pc, 0);
    ex_ec = 1; inst_valid = 1; pc = 32'hC00; tvec = 32'hD00;
    do_txn("rc.ecall", 1, 11, 0, 32'hC00, 32'hD00);

    // Random single-instruction transactions
    for (int n = 0; n < 300; n++) begin
      x.v = ($urandom_range(9) != 0);
      for (int b = 0; b < 6; b++) x.ex[b] = ($urandom_range(5) == 0);
      x.mret = ($urandom_range(3) == 0); x.mst = $urandom_range(1);
      x.mie = $urandom_range(7); x.mip = $urandom_range(7);
      x.pc = $urandom; x.inst = $urandom; x.bad = $urandom;
      x.tvec = $urandom; x.epc = $urandom;
      ref_evt(x.v, x.ex, x.mret, x.mst, x.mie, x.mip, x.pc, x.inst, x.bad, k, c, t);
      apply(x);
      do_txn($sformatf("rnd%0d", n), k, c, t, x.pc, k == 2 ? x.epc : x.tvec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
